axi4lite_slave_bridge: RTL and testbench
========================================

// Module: axi4lite_slave_bridge
// PURPOSE
//  AXI4-Lite slave to native register bus bridge; successor to the basic adapter.
//  - AW and W are accepted independently.
//  - The native bus has wait states and errors (reg_ready/reg_err) and an optional timeout.
//  - An address window gives DECERR outside the window; reads and writes are arbitrated fairly.
//  - Sits between the AXI interconnect and each IP register file.
// PARAMETERS
//  ADDR_WIDTH      32       AXI/native address width
//  DATA_WIDTH      32       data width; 32 or 64
//  BASE_ADDR       '0       window base; must be aligned to ADDR_SPAN
//  ADDR_SPAN       4096     window size in bytes; power of 2
//  TIMEOUT_CYCLES  256      max cycles waiting on reg_ready; 0 disables the timeout
// PORTS
//  aclk           in   1             clock
//  areset         in   1             synchronous reset, active-high
//  s_axi_awaddr   in   ADDR_WIDTH    write address
//  s_axi_awprot   in   3             unused
//  s_axi_awvalid  in   1             /  s_axi_awready  out 1
//  s_axi_wdata    in   DATA_WIDTH    write data
//  s_axi_wstrb    in   DATA_WIDTH/8  byte strobes
//  s_axi_wvalid   in   1             /  s_axi_wready   out 1
//  s_axi_bresp    out  2             write response
//  s_axi_bvalid   out  1             /  s_axi_bready   in  1
//  s_axi_araddr   in   ADDR_WIDTH    read address
//  s_axi_arprot   in   3             unused
//  s_axi_arvalid  in   1             /  s_axi_arready  out 1
//  s_axi_rdata    out  DATA_WIDTH    read data
//  s_axi_rresp    out  2             read response
//  s_axi_rvalid   out  1             /  s_axi_rready   in  1
//  reg_addr       out  ADDR_WIDTH    byte offset from BASE_ADDR, word-aligned (low bits cleared)
//  reg_wdata      out  DATA_WIDTH    write data
//  reg_be         out  DATA_WIDTH/8  byte enables (= wstrb)
//  reg_we         out  1             write request; level, held until reg_ready
//  reg_re         out  1             read request; level, held until reg_ready
//  reg_rdata      in   DATA_WIDTH    sampled on the reg_ready cycle of a read
//  reg_ready      in   1             access complete (may be high on the first request cycle)
//  reg_err        in   1             qualifies reg_ready; gives SLVERR
// BEHAVIOUR
//  Reset (areset=1, sampled at posedge):
//   - All outputs 0: ready, valid, resp, rdata, reg_*; FSM -> IDLE; buffers empty; last_grant=READ.
//   - Mid-transaction reset abandons the access; no response is issued.
//  Input buffers:
//   - One-deep hold register per AW, W and AR channel.
//   - Each *ready is registered and equals !buffer_full; it is 1 from the first cycle after reset.
//   - Handshake when valid&ready; the buffer fills next cycle; ready drops.
//  FSM states: IDLE, WACC, RACC, WRESP, RRESP.
//   IDLE:
//   - Write is eligible when AW and W are both full; read is eligible when AR is full.
//   - Both eligible: grant the opposite of last_grant, then update last_grant.
//   - Out-of-window address (addr-BASE_ADDR >= ADDR_SPAN): no native access.
//     Go directly to WRESP/RRESP with DECERR (2'b11), rdata=0.
//   WACC/RACC:
//   - reg_we/reg_re=1 from the cycle after the grant.
//   - Buffer(s) freed on entry; ready rises the next cycle.
//   - On reg_ready: resp = reg_err ? SLVERR : OKAY; rdata latched.
//   - Then -> WRESP/RRESP.
//   - Timeout (TIMEOUT_CYCLES>0): the counter starts at 0 on the first request cycle.
//     At count==TIMEOUT_CYCLES-1 without reg_ready: drop the request, resp=SLVERR, rdata=0.
//   WRESP/RRESP:
//   - bvalid/rvalid=1 with resp/rdata stable until bready/rready; then -> IDLE the next cycle.
//  Latency: handshake at cycle 0 -> request cycle 1 -> (reg_ready in cycle 1) valid in cycle 2.
//  Only one native access at a time; reg_we and reg_re are never both high.
//  Buffers keep accepting new addresses/data during an access or response (pipelining).
//  AW before W or W before AW, any cycle gap: the write waits until both are full.
//  Response codes are constants from the package; EXOKAY is never issued.
// STRUCTURE
//  axi4lite_pkg:
//  - axi_resp_e {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11}
//  - bridge_state_e
//  Sub-module axi4lite_hold_reg #(WIDTH): one-deep valid/ready register.
//  - Three instances: AW {addr}, W {data,strb}, AR {addr}.
//  - The top level holds the FSM, arbiter, timeout counter and decode.
// TESTING
//  1. Write 0x10 <- 0xDEADBEEF, wstrb=0xF, reg_ready tied 1.
//     -> reg_we one cycle, reg_addr=0x10; bvalid 2 cycles after the handshake, bresp=00.
//  2. AW at cycle 0, W at cycle 5.
//     -> no reg_we before cycle 6; reg_we in cycle 6, then normal completion.
//  3. Read 0x20, reg_ready delayed 3 cycles, reg_rdata=0x12345678.
//     -> reg_re held 4 cycles; rdata=0x12345678, rresp=00.
//  4. Read at BASE_ADDR+ADDR_SPAN.
//     -> no reg_re; rresp=11, rdata=0.
//  5. TIMEOUT_CYCLES=8, reg_ready stuck 0 on a write.
//     -> reg_we exactly 8 cycles; bresp=10; the next access still works.
//  6. Write pair and read buffered together, twice back-to-back.
//     -> order W,R,W,R; reg_err=1 on the 2nd read -> rresp=10; bready held 0 -> bvalid stays.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite slave bridge: response codes, FSM states and
// the read/write arbitration token.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WACC,
    ST_RACC,
    ST_WRESP,
    ST_RRESP
  } bridge_state_e;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

  // Counter width able to hold 0 .. v-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v > 2) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/axi4lite_hold_reg.sv
// One-deep valid/ready hold register: captures a beat on handshake and keeps
// it until the consumer pops it. Ready is registered and tracks !full.
module axi4lite_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             pop_i
);

  logic             full_q, full_d;
  logic             ready_q;
  logic [WIDTH-1:0] data_q;

  // Pop only happens while full and a handshake only while empty, so the two
  // branches never compete in the same cycle.
  always_comb begin
    full_d = full_q;
    if (pop_i) begin
      full_d = 1'b0;
    end else if (in_valid_i && ready_q) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      ready_q <= !full_d;
    end
  end

  // NOTE: the payload register has no reset; full_q alone says whether it holds
  // anything meaningful, so resetting it would only add fan-out.
  always_ff @(posedge clk_i) begin
    if (in_valid_i && ready_q) begin
      data_q <= in_data_i;
    end
  end

  assign in_ready_o = ready_q;
  assign full_o     = full_q;
  assign data_o     = data_q;

endmodule

// File: rtl/axi4lite_slave_bridge.sv
// AXI4-Lite slave to native register bus bridge with per-channel hold
// registers, fair read/write arbitration, address-window decode and timeout.
module axi4lite_slave_bridge
  import axi4lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           ADDR_SPAN      = 4096,
  parameter int unsigned           TIMEOUT_CYCLES = 256
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_be,
  output logic                    reg_we,
  output logic                    reg_re,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic                    reg_ready,
  input  logic                    reg_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int TMO_W  = int'(cnt_width(TIMEOUT_CYCLES));
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(STRB_W - 1);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  // Offset is taken modulo 2^ADDR_WIDTH, so addresses below the base wrap to a
  // large value and fall outside the window as well.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] offset;
    offset = {1'b0, addr - BASE_ADDR};
    return offset < (ADDR_WIDTH + 1)'(ADDR_SPAN);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_offset(input logic [ADDR_WIDTH-1:0] addr);
    return (addr - BASE_ADDR) & WORD_MASK;
  endfunction

  // ---------------------------------------------------------------- buffers
  logic                  aw_full, w_full, ar_full;
  logic                  aw_pop, w_pop, ar_pop;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [DATA_WIDTH+STRB_W-1:0] w_payload;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;

  axi4lite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk_i      (aclk),
    .rst_i      (areset),
    .in_valid_i (s_axi_awvalid),
    .in_ready_o (s_axi_awready),
    .in_data_i  (s_axi_awaddr),
    .full_o     (aw_full),
    .data_o     (aw_addr),
    .pop_i      (aw_pop)
  );

  axi4lite_hold_reg #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_hold (
    .clk_i      (aclk),
    .rst_i      (areset),
    .in_valid_i (s_axi_wvalid),
    .in_ready_o (s_axi_wready),
    .in_data_i  ({s_axi_wdata, s_axi_wstrb}),
    .full_o     (w_full),
    .data_o     (w_payload),
    .pop_i      (w_pop)
  );

  axi4lite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
    .clk_i      (aclk),
    .rst_i      (areset),
    .in_valid_i (s_axi_arvalid),
    .in_ready_o (s_axi_arready),
    .in_data_i  (s_axi_araddr),
    .full_o     (ar_full),
    .data_o     (ar_addr),
    .pop_i      (ar_pop)
  );

  assign w_data = w_payload[DATA_WIDTH+STRB_W-1:STRB_W];
  assign w_strb = w_payload[STRB_W-1:0];

  // Protection bits carry no meaning for the native bus.
  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  // ---------------------------------------------------------------- arbiter
  bridge_state_e         state_q;
  grant_e                last_grant_q;
  logic                  grant_wr, grant_rd;
  logic                  wr_elig, rd_elig;

  always_comb begin
    wr_elig  = aw_full && w_full;
    rd_elig  = ar_full;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == ST_IDLE) begin
      if (wr_elig && rd_elig) begin
        grant_wr = (last_grant_q == GRANT_READ);
        grant_rd = (last_grant_q == GRANT_WRITE);
      end else begin
        grant_wr = wr_elig;
        grant_rd = rd_elig;
      end
    end
    aw_pop = grant_wr;
    w_pop  = grant_wr;
    ar_pop = grant_rd;
  end

  // ---------------------------------------------------------------- FSM
  logic                  reg_we_q, reg_re_q;
  logic [ADDR_WIDTH-1:0] reg_addr_q;
  logic [DATA_WIDTH-1:0] reg_wdata_q;
  logic [STRB_W-1:0]     reg_be_q;
  logic                  bvalid_q, rvalid_q;
  axi_resp_e             bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [TMO_W-1:0]      tmo_cnt_q;
  logic                  tmo_hit;

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_READ;
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_be_q     <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= OKAY;
      rvalid_q     <= 1'b0;
      rresp_q      <= OKAY;
      rdata_q      <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmo_cnt_q <= '0;
          if (grant_wr) begin
            last_grant_q <= GRANT_WRITE;
            if (in_window(aw_addr)) begin
              state_q     <= ST_WACC;
              reg_we_q    <= 1'b1;
              reg_addr_q  <= word_offset(aw_addr);
              reg_wdata_q <= w_data;
              reg_be_q    <= w_strb;
            end else begin
              state_q  <= ST_WRESP;
              bvalid_q <= 1'b1;
              bresp_q  <= DECERR;
            end
          end else if (grant_rd) begin
            last_grant_q <= GRANT_READ;
            if (in_window(ar_addr)) begin
              state_q    <= ST_RACC;
              reg_re_q   <= 1'b1;
              reg_addr_q <= word_offset(ar_addr);
            end else begin
              state_q  <= ST_RRESP;
              rvalid_q <= 1'b1;
              rresp_q  <= DECERR;
              rdata_q  <= '0;
            end
          end
        end

        ST_WACC: begin
          if (reg_ready) begin
            reg_we_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= reg_err ? SLVERR : OKAY;
            state_q  <= ST_WRESP;
          end else if (tmo_hit) begin
            reg_we_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= SLVERR;
            state_q  <= ST_WRESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        ST_RACC: begin
          if (reg_ready) begin
            reg_re_q <= 1'b0;
            rvalid_q <= 1'b1;
            rresp_q  <= reg_err ? SLVERR : OKAY;
            rdata_q  <= reg_rdata;
            state_q  <= ST_RRESP;
          end else if (tmo_hit) begin
            reg_re_q <= 1'b0;
            rvalid_q <= 1'b1;
            rresp_q  <= SLVERR;
            rdata_q  <= '0;
            state_q  <= ST_RRESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        ST_WRESP: begin
          if (s_axi_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end

        ST_RRESP: begin
          if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign reg_we       = reg_we_q;
  assign reg_re       = reg_re_q;
  assign reg_addr     = reg_addr_q;
  assign reg_wdata    = reg_wdata_q;
  assign reg_be       = reg_be_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;

endmodule

// File: tb/tb_axi4lite_slave_bridge.sv
// Scoreboard bench for axi4lite_slave_bridge: stimulus pushes expected native
// requests and AXI responses; independent monitors pop and compare.
module tb_axi4lite_slave_bridge;
  import axi4lite_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          SPAN = 4096;
  localparam int          TMO  = 8;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_axi_awaddr = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic        reg_we, reg_re;
  logic [31:0] reg_rdata = '0;
  logic        reg_ready = 1'b0;
  logic        reg_err = 1'b0;

  logic b_hold = 1'b0;
  assign s_axi_bready = !b_hold;
  assign s_axi_rready = 1'b1;

  always #5 aclk = ~aclk;

  axi4lite_slave_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE),
    .ADDR_SPAN(SPAN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .reg_ready(reg_ready), .reg_err(reg_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          start;   // expected first request cycle, -1 = don't care
    int          delay;   // request cycles before reg_ready
    logic        stuck;   // never answer
    logic        err;
    logic [31:0] rdata;
  } req_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;     // expected first valid cycle, -1 = don't care
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_b[$];
  rsp_t exp_r[$];

  int vec_cnt = 0;
  int miscmp  = 0;
  int cyc     = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t mk_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] be, input int start, input int delay,
                                  input logic stuck, input logic err, input logic [31:0] rdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.be = be; r.start = start;
    r.delay = delay; r.stuck = stuck; r.err = err; r.rdata = rdata;
    return r;
  endfunction

  function automatic rsp_t mk_rsp(input logic [1:0] resp, input logic [31:0] data, input int c);
    rsp_t r;
    r.resp = resp; r.data = data; r.cyc = c;
    return r;
  endfunction

  // ------------------------------------------------ native monitor + responder
  req_t cur;
  bit   in_req  = 1'b0;
  int   req_len = 0;

  always @(negedge aclk) begin
    if (reg_we || reg_re) check("we_re_exclusive", reg_we & reg_re, 0);
    if ((reg_we || reg_re) && !in_req) begin
      in_req  = 1'b1;
      req_len = 0;
      if (exp_req.size() == 0) begin
        check("unexpected_req", {reg_we, reg_re}, 0);
        cur = mk_req(reg_we, reg_addr, reg_wdata, reg_be, -1, 0, 1'b0, 1'b0, '0);
      end else begin
        cur = exp_req.pop_front();
        check("req_dir", reg_we, cur.we);
        check("req_addr", reg_addr, cur.addr);
        if (cur.we) begin
          check("req_wdata", reg_wdata, cur.wdata);
          check("req_be", reg_be, cur.be);
        end
        if (cur.start >= 0) check("req_start_cycle", cyc, cur.start);
      end
    end
    if (reg_we || reg_re) begin
      reg_ready = !cur.stuck && (req_len == cur.delay);
      reg_err   = cur.err && reg_ready;
      reg_rdata = cur.rdata;
      req_len++;
    end else begin
      if (in_req) begin
        check("req_len", req_len, cur.stuck ? TMO : cur.delay + 1);
        in_req = 1'b0;
      end
      reg_ready = 1'b0;
      reg_err   = 1'b0;
    end
  end

  // ------------------------------------------------ B / R monitors
  logic b_prev = 1'b0, r_prev = 1'b0;
  int   b_start = 0, r_start = 0;

  always @(negedge aclk) begin
    rsp_t e;
    if (s_axi_bvalid && !b_prev) b_start = cyc;
    b_prev = s_axi_bvalid && !s_axi_bready;
    if (s_axi_bvalid && s_axi_bready) begin
      if (exp_b.size() == 0) begin
        check("unexpected_b", s_axi_bvalid, 0);
      end else begin
        e = exp_b.pop_front();
        check("bresp", s_axi_bresp, e.resp);
        if (e.cyc >= 0) check("bvalid_cycle", b_start, e.cyc);
      end
    end
  end

  always @(negedge aclk) begin
    rsp_t e;
    if (s_axi_rvalid && !r_prev) r_start = cyc;
    r_prev = s_axi_rvalid && !s_axi_rready;
    if (s_axi_rvalid && s_axi_rready) begin
      if (exp_r.size() == 0) begin
        check("unexpected_r", s_axi_rvalid, 0);
      end else begin
        e = exp_r.pop_front();
        check("rresp", s_axi_rresp, e.resp);
        check("rdata", s_axi_rdata, e.data);
        if (e.cyc >= 0) check("rvalid_cycle", r_start, e.cyc);
      end
    end
  end

  // ------------------------------------------------ stimulus tasks
  // Each returns the cycle number of the handshake edge (-1 on timeout).
  task automatic send_aw(input logic [31:0] a, output int h);
    int t = 0;
    @(negedge aclk);
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && t < 200) begin @(negedge aclk); t++; end
    if (!s_axi_awready) begin
      check("aw_handshake_timeout", s_axi_awready, 1);
      s_axi_awvalid = 1'b0; h = -1;
    end else begin
      @(posedge aclk); #1;
      h = cyc; s_axi_awvalid = 1'b0;
    end
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int h);
    int t = 0;
    @(negedge aclk);
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    while (!s_axi_wready && t < 200) begin @(negedge aclk); t++; end
    if (!s_axi_wready) begin
      check("w_handshake_timeout", s_axi_wready, 1);
      s_axi_wvalid = 1'b0; h = -1;
    end else begin
      @(posedge aclk); #1;
      h = cyc; s_axi_wvalid = 1'b0;
    end
  endtask

  task automatic send_ar(input logic [31:0] a, output int h);
    int t = 0;
    @(negedge aclk);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && t < 200) begin @(negedge aclk); t++; end
    if (!s_axi_arready) begin
      check("ar_handshake_timeout", s_axi_arready, 1);
      s_axi_arvalid = 1'b0; h = -1;
    end else begin
      @(posedge aclk); #1;
      h = cyc; s_axi_arvalid = 1'b0;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int h);
    int ha, hw;
    fork
      send_aw(a, ha);
      send_w(d, s, hw);
    join
    h = (ha > hw) ? ha : hw;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_req.size() != 0 || exp_b.size() != 0 || exp_r.size() != 0 || in_req) && t < 300) begin
      @(negedge aclk); t++;
    end
    if (t >= 300) check("drain_timeout", exp_req.size() + exp_b.size() + exp_r.size(), 0);
    repeat (2) @(negedge aclk);
  endtask

  // ------------------------------------------------ main sequence
  int h, ha, hw, h6a, h6b;

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    check("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
    check("rst_resps", {s_axi_bresp, s_axi_rresp}, 4'h0);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_reg_ctl", {reg_we, reg_re, reg_be}, 0);
    check("rst_reg_addr", {reg_addr, reg_wdata}, 0);
    areset = 1'b0;
    @(negedge aclk);
    check("readys_after_rst", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    // 1: single write, immediate native completion
    do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, h);
    exp_req.push_back(mk_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, h + 1, 0, 1'b0, 1'b0, '0));
    exp_b.push_back(mk_rsp(OKAY, '0, h + 2));
    wait_idle();

    // 2: AW first, W five cycles later
    send_aw(BASE + 32'h24, ha);
    repeat (4) @(negedge aclk);
    send_w(32'hA5A5_0F0F, 4'h3, hw);
    exp_req.push_back(mk_req(1'b1, 32'h24, 32'hA5A5_0F0F, 4'h3, hw + 1, 0, 1'b0, 1'b0, '0));
    exp_b.push_back(mk_rsp(OKAY, '0, hw + 2));
    wait_idle();

    // 3: read with three wait states
    send_ar(BASE + 32'h20, h);
    exp_req.push_back(mk_req(1'b0, 32'h20, '0, '0, h + 1, 3, 1'b0, 1'b0, 32'h1234_5678));
    exp_r.push_back(mk_rsp(OKAY, 32'h1234_5678, h + 5));
    wait_idle();

    // 4: window edges
    send_ar(BASE + SPAN, h);
    exp_r.push_back(mk_rsp(DECERR, '0, h + 1));
    wait_idle();
    send_ar(BASE - 32'h4, h);
    exp_r.push_back(mk_rsp(DECERR, '0, h + 1));
    wait_idle();
    do_write(BASE + 32'h2000, 32'h0000_0001, 4'hF, h);
    exp_b.push_back(mk_rsp(DECERR, '0, h + 1));
    wait_idle();
    do_write(BASE + 32'hFFF, 32'h0102_0304, 4'h8, h);
    exp_req.push_back(mk_req(1'b1, 32'hFFC, 32'h0102_0304, 4'h8, h + 1, 0, 1'b0, 1'b0, '0));
    exp_b.push_back(mk_rsp(OKAY, '0, h + 2));
    wait_idle();

    // 5: native bus never answers a write; next access still works
    do_write(BASE + 32'h40, 32'h5555_AAAA, 4'hF, h);
    exp_req.push_back(mk_req(1'b1, 32'h40, 32'h5555_AAAA, 4'hF, h + 1, 0, 1'b1, 1'b0, '0));
    exp_b.push_back(mk_rsp(SLVERR, '0, h + 1 + TMO));
    wait_idle();
    send_ar(BASE + 32'h44, h);
    exp_req.push_back(mk_req(1'b0, 32'h44, '0, '0, h + 1, 1, 1'b0, 1'b0, 32'hCAFE_F00D));
    exp_r.push_back(mk_rsp(OKAY, 32'hCAFE_F00D, h + 3));
    wait_idle();

    // 6: two write/read sets competing; fair order W,R,W,R; error on second read
    exp_req.push_back(mk_req(1'b1, 32'h100, 32'h1111_1111, 4'hF, -1, 0, 1'b0, 1'b0, '0));
    exp_req.push_back(mk_req(1'b0, 32'h104, '0, '0, -1, 0, 1'b0, 1'b0, 32'hBBBB_0001));
    exp_req.push_back(mk_req(1'b1, 32'h108, 32'h2222_2222, 4'hC, -1, 1, 1'b0, 1'b0, '0));
    exp_req.push_back(mk_req(1'b0, 32'h10C, '0, '0, -1, 0, 1'b0, 1'b1, 32'h0BAD_0BAD));
    exp_b.push_back(mk_rsp(OKAY, '0, -1));
    exp_b.push_back(mk_rsp(OKAY, '0, -1));
    exp_r.push_back(mk_rsp(OKAY, 32'hBBBB_0001, -1));
    exp_r.push_back(mk_rsp(SLVERR, 32'h0BAD_0BAD, -1));
    @(posedge aclk); #1 b_hold = 1'b1;
    fork
      do_write(BASE + 32'h100, 32'h1111_1111, 4'hF, h6a);
      send_ar(BASE + 32'h104, h6b);
    join
    fork
      do_write(BASE + 32'h108, 32'h2222_2222, 4'hC, h6a);
      send_ar(BASE + 32'h10C, h6b);
    join_none
    begin
      int t = 0;
      while (!s_axi_bvalid && t < 50) begin @(negedge aclk); t++; end
      if (!s_axi_bvalid) check("b_wait_timeout", s_axi_bvalid, 1);
    end
    repeat (3) begin
      @(negedge aclk);
      check("b_held_valid", s_axi_bvalid, 1);
      check("b_held_resp", s_axi_bresp, OKAY);
      check("b_held_no_read", {s_axi_rvalid, reg_re}, 2'b00);
    end
    @(posedge aclk); #1 b_hold = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
